codec_i2c_config: RTL and testbench



---
 rtl/codec_cfg_pkg.sv | 34 +++
 rtl/i2c_write_master.sv | 156 +++++++++++++++
 rtl/codec_i2c_config.sv | 137 +++++++++++++
 tb/tb_codec_i2c_config.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_cfg_pkg.sv
// Shared types and the fixed WM8731 register table for the codec I2C configuration block.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    SEQ_PWR_WAIT,
    SEQ_XFER,
    SEQ_GAP,
    SEQ_DONE,
    SEQ_ERROR
  } seq_state_t;

  typedef enum logic [2:0] {
    MST_IDLE,
    MST_START,
    MST_BIT,
    MST_ACK,
    MST_STOP
  } mst_state_t;

  localparam int NUM_WORDS = 11;
  localparam logic [7:0] DEV_WR_BYTE = 8'h34;

  // Each word is {reg[6:0], data[8:0]}; sent as word[15:8] then word[7:0].
  localparam logic [15:0] CFG_TABLE [NUM_WORDS] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
    16'h0A00, 16'h0C00, 16'h0E09, 16'h1001, 16'h1201
  };

  function automatic logic [15:0] cfg_word(input logic [3:0] idx);
    if (int'(idx) < NUM_WORDS) return CFG_TABLE[idx];
    return 16'h0000;
  endfunction

endpackage

// File: rtl/i2c_write_master.sv
// Write-only I2C master: START, three bytes with ACK checks, STOP. Every bus phase is one quarter
// of the SCL period; a NACK on any byte aborts straight to STOP.
module i2c_write_master
  import codec_cfg_pkg::*;
#(
  parameter int SCL_QDIV = 30
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_frame,
  input  logic        i_start,
  input  logic        i_sda,
  output logic        o_scl,
  output logic        o_sda_oe,
  output logic        o_done,
  output logic        o_nack
);

  localparam int QW = (SCL_QDIV > 1) ? $clog2(SCL_QDIV) : 1;

  mst_state_t    state, state_n;
  logic [QW-1:0] qcnt;
  logic [1:0]    q, q_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [1:0]    byte_cnt, byte_n;
  logic [23:0]   shreg, shreg_n;
  logic          scl_n, sda_oe_n, nack_n, done_n;
  logic          tick;

  assign tick = (qcnt == QW'(SCL_QDIV - 1));

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (i_rst) begin
      state    <= MST_IDLE;
      qcnt     <= '0;
      q        <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      o_scl    <= 1'b1;
      o_sda_oe <= 1'b0;
      o_nack   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state    <= state_n;
      qcnt     <= (state == MST_IDLE || tick) ? '0 : qcnt + QW'(1);
      q        <= q_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      shreg    <= shreg_n;
      o_scl    <= scl_n;
      o_sda_oe <= sda_oe_n;
      o_nack   <= nack_n;
      o_done   <= done_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n  = state;
    q_n      = q;
    bit_n    = bit_cnt;
    byte_n   = byte_cnt;
    shreg_n  = shreg;
    scl_n    = o_scl;
    sda_oe_n = o_sda_oe;
    nack_n   = o_nack;
    done_n   = 1'b0;

    unique case (state)
      MST_IDLE: begin
        if (i_start) begin
          state_n  = MST_START;
          q_n      = 2'd0;
          shreg_n  = i_frame;
          bit_n    = 3'd7;
          byte_n   = 2'd0;
          nack_n   = 1'b0;
          scl_n    = 1'b1;
          sda_oe_n = 1'b1;
        end
      end
      MST_START: begin
        if (tick) begin
          if (q == 2'd0) begin
            q_n   = 2'd1;
            scl_n = 1'b0;
          end else begin
            state_n  = MST_BIT;
            q_n      = 2'd0;
            sda_oe_n = ~shreg[23];
          end
        end
      end
      MST_BIT: begin
        if (tick) begin
          q_n = q + 2'd1;
          unique case (q)
            2'd0: scl_n = 1'b1;
            2'd1: ;
            2'd2: scl_n = 1'b0;
            2'd3: begin
              if (bit_cnt == 3'd0) begin
                state_n  = MST_ACK;
                sda_oe_n = 1'b0;
              end else begin
                bit_n    = bit_cnt - 3'd1;
                shreg_n  = {shreg[22:0], 1'b0};
                sda_oe_n = ~shreg[22];
              end
            end
          endcase
        end
      end
      MST_ACK: begin
        if (tick) begin
          q_n = q + 2'd1;
          unique case (q)
            2'd0: scl_n = 1'b1;
            2'd1: nack_n = o_nack | i_sda;  // last clock of the SCL-high quarter
            2'd2: scl_n = 1'b0;
            2'd3: begin
              if (o_nack || byte_cnt == 2'd2) begin
                state_n  = MST_STOP;
                sda_oe_n = 1'b1;
              end else begin
                state_n  = MST_BIT;
                byte_n   = byte_cnt + 2'd1;
                bit_n    = 3'd7;
                shreg_n  = {shreg[22:0], 1'b0};
                sda_oe_n = ~shreg[22];
              end
            end
          endcase
        end
      end
      MST_STOP: begin
        if (tick) begin
          q_n = q + 2'd1;
          unique case (q)
            2'd0: scl_n = 1'b1;
            2'd1: sda_oe_n = 1'b0;
            default: begin
              state_n = MST_IDLE;
              q_n     = 2'd0;
              done_n  = 1'b1;
            end
          endcase
        end
      end
      default: state_n = MST_IDLE;
    endcase
  end

endmodule

// File: rtl/codec_i2c_config.sv
// WM8731 configuration sequencer: power-up wait, one I2C write per table word with retry on NACK,
// bus-idle gap after each STOP, then a config-done level for the codec data stage.
module codec_i2c_config
  import codec_cfg_pkg::*;
#(
  parameter int         SCL_QDIV   = 30,
  parameter int         PWR_CYCLES = 12000,
  parameter int         GAP_CYCLES = 600,
  parameter int         MAX_RETRY  = 3,
  parameter logic [6:0] DEV_ADDR   = DEV_WR_BYTE[7:1]
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_restart,
  input  logic       i_sda,
  output logic       o_scl,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic [3:0] o_word_idx,
  output logic       o_config_done,
  output logic       o_error
);

  localparam int CNT_MAX = (PWR_CYCLES > GAP_CYCLES) ? PWR_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  seq_state_t         state, state_n, gap_dest, gap_dest_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [3:0]         word_idx, word_idx_n;
  logic [RETRY_W-1:0] retry, retry_n;
  logic               start, start_n;
  logic [23:0]        frame;
  logic               xfer_done, xfer_nack;

  assign frame = {DEV_ADDR, 1'b0, cfg_word(word_idx)};

  i2c_write_master #(
    .SCL_QDIV (SCL_QDIV)
  ) u_master (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_frame  (frame),
    .i_start  (start),
    .i_sda    (i_sda),
    .o_scl    (o_scl),
    .o_sda_oe (o_sda_oe),
    .o_done   (xfer_done),
    .o_nack   (xfer_nack)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= SEQ_PWR_WAIT;
      gap_dest <= SEQ_XFER;
      cnt      <= '0;
      word_idx <= '0;
      retry    <= '0;
      start    <= 1'b0;
    end else begin
      state    <= state_n;
      gap_dest <= gap_dest_n;
      cnt      <= cnt_n;
      word_idx <= word_idx_n;
      retry    <= retry_n;
      start    <= start_n;
    end
  end

  always_comb begin
    state_n    = state;
    gap_dest_n = gap_dest;
    cnt_n      = cnt;
    word_idx_n = word_idx;
    retry_n    = retry;
    start_n    = 1'b0;

    unique case (state)
      SEQ_PWR_WAIT: begin
        if (cnt == CNT_W'(PWR_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = SEQ_XFER;
          start_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SEQ_XFER: begin
        if (xfer_done) begin
          state_n = SEQ_GAP;
          cnt_n   = '0;
          // The destination is decided now and taken once the gap has elapsed.
          if (xfer_nack) begin
            if (retry < RETRY_W'(MAX_RETRY)) begin
              retry_n    = retry + RETRY_W'(1);
              gap_dest_n = SEQ_XFER;
            end else begin
              gap_dest_n = SEQ_ERROR;
            end
          end else begin
            retry_n = '0;
            if (word_idx == 4'(NUM_WORDS - 1)) begin
              gap_dest_n = SEQ_DONE;
            end else begin
              word_idx_n = word_idx + 4'd1;
              gap_dest_n = SEQ_XFER;
            end
          end
        end
      end
      SEQ_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = gap_dest;
          start_n = (gap_dest == SEQ_XFER);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SEQ_DONE, SEQ_ERROR: begin
        if (i_restart) begin
          state_n    = SEQ_PWR_WAIT;
          cnt_n      = '0;
          word_idx_n = '0;
          retry_n    = '0;
        end
      end
      default: state_n = SEQ_PWR_WAIT;
    endcase
  end

  assign o_busy        = (state != SEQ_DONE) && (state != SEQ_ERROR);
  assign o_config_done = (state == SEQ_DONE);
  assign o_error       = (state == SEQ_ERROR);
  assign o_word_idx    = word_idx;

endmodule

// File: tb/tb_codec_i2c_config.sv
// Bench for codec_i2c_config: an I2C slave model decodes the bus and ACKs/NACKs per policy, and a
// transaction-level reference model predicts the byte stream and the final DONE/ERROR outcome.
module tb_codec_i2c_config;

  localparam int QDIV   = 5;
  localparam int PWR    = 300;
  localparam int GAP    = 50;
  localparam int MAXR   = 3;
  localparam int PERIOD = 4 * QDIV;
  localparam int LIMIT  = 15000;

  logic       clk;
  logic       i_rst, i_restart, sda_line;
  logic       o_scl, o_sda_oe, o_busy, o_config_done, o_error;
  logic [3:0] o_word_idx;

  typedef struct {
    int          n;
    logic [23:0] bytes;
    int          pmin;
    int          pmax;
  } xfer_t;

  xfer_t got_q[$];
  xfer_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave / monitor state
  bit          slave_pull = 1'b0;
  bit          prev_scl, prev_sda, sda_now;
  bit          mon_in_xfer, ack_pending, ack_active;
  int          mon_starts, mon_glitches, mon_nbits, mon_nbytes;
  int          mon_first_start_cyc, mon_last_stop_cyc, last_rise, pmin, pmax;
  logic [7:0]  sh;
  logic [23:0] cur;

  // slave NACK policy
  int nack_xfer = -1;
  int nack_byte = 0;
  bit nack_always = 1'b0;

  codec_i2c_config #(
    .SCL_QDIV   (QDIV),
    .PWR_CYCLES (PWR),
    .GAP_CYCLES (GAP),
    .MAX_RETRY  (MAXR),
    .DEV_ADDR   (7'h1A)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_restart     (i_restart),
    .i_sda         (sda_line),
    .o_scl         (o_scl),
    .o_sda_oe      (o_sda_oe),
    .o_busy        (o_busy),
    .o_word_idx    (o_word_idx),
    .o_config_done (o_config_done),
    .o_error       (o_error)
  );

  assign sda_line = ~(o_sda_oe | slave_pull);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [15:0] ref_word(input int w);
    case (w)
      0: return 16'h1E00;  1: return 16'h0017;  2: return 16'h0217;
      3: return 16'h0479;  4: return 16'h0679;  5: return 16'h0812;
      6: return 16'h0A00;  7: return 16'h0C00;  8: return 16'h0E09;
      9: return 16'h1001;  10: return 16'h1201;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit slave_nacks(input int xn, input int bi);
    if (nack_always) return bi == nack_byte;
    return (xn == nack_xfer) && (bi == nack_byte);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: which bytes appear on the bus, and whether the run ends in DONE or ERROR.
  task automatic build_expected(output int end_kind);
    int w = 0;
    int retry = 0;
    int xn = 0;
    exp_q.delete();
    end_kind = 0;
    while (xn < 100) begin
      int    b = 3;
      xfer_t e;
      for (int bi = 2; bi >= 0; bi--) if (slave_nacks(xn, bi)) b = bi;
      e.n     = (b < 3) ? b + 1 : 3;
      e.bytes = {8'h34, ref_word(w)} & ~(24'hFFFFFF >> (8 * e.n));
      e.pmin  = PERIOD;
      e.pmax  = PERIOD;
      exp_q.push_back(e);
      xn++;
      if (b < 3) begin
        if (retry < MAXR) retry++;
        else begin end_kind = 2; break; end
      end else begin
        retry = 0;
        if (w == 10) begin end_kind = 1; break; end
        w++;
      end
    end
  endtask

  // Bus monitor and slave, sampled on the falling clock edge.
  initial forever begin
    @(negedge clk);
    if (i_rst) begin
      slave_pull  = 1'b0;
      mon_in_xfer = 1'b0;
      ack_pending = 1'b0;
      ack_active  = 1'b0;
      prev_scl    = 1'b1;
      prev_sda    = 1'b1;
    end else begin
      sda_now = sda_line;
      if (prev_scl && o_scl && prev_sda && !sda_now) begin
        if (mon_in_xfer) mon_glitches++;
        mon_in_xfer = 1'b1;
        mon_nbits   = 0;
        mon_nbytes  = 0;
        cur         = '0;
        last_rise   = -1;
        pmin        = 1000000;
        pmax        = 0;
        mon_starts++;
        if (mon_starts == 1) mon_first_start_cyc = cyc;
      end else if (prev_scl && o_scl && !prev_sda && sda_now) begin
        if (!mon_in_xfer || mon_nbits != 1) mon_glitches++;
        if (mon_in_xfer) got_q.push_back('{mon_nbytes, cur, pmin, pmax});
        mon_in_xfer       = 1'b0;
        mon_last_stop_cyc = cyc;
      end else if (!prev_scl && o_scl && mon_in_xfer) begin
        if (last_rise >= 0) begin
          if (cyc - last_rise < pmin) pmin = cyc - last_rise;
          if (cyc - last_rise > pmax) pmax = cyc - last_rise;
        end
        last_rise = cyc;
        if (mon_nbits < 8) begin
          sh = {sh[6:0], sda_now};
          mon_nbits++;
          if (mon_nbits == 8) begin
            if (mon_nbytes < 3) cur = cur | (24'(sh) << (8 * (2 - mon_nbytes)));
            ack_pending = 1'b1;
          end
        end else begin
          mon_nbytes++;
          mon_nbits = 0;
        end
      end else if (prev_scl && !o_scl) begin
        if (ack_pending) begin
          slave_pull  = !slave_nacks(mon_starts - 1, mon_nbytes);
          ack_pending = 1'b0;
          ack_active  = 1'b1;
        end else if (ack_active) begin
          slave_pull = 1'b0;
          ack_active = 1'b0;
        end
      end
      prev_scl = o_scl;
      prev_sda = sda_now;
    end
  end

  // kick: 0 = release reset, 1 = restart pulse. hook: 1 = restart during word 1, 2 = reset during word 5.
  task automatic run_table(input string tag, input int kick, input int hook);
    int exp_end, exp_delay, base, done_cyc, d, nchk;
    bit hooked = 1'b0;
    build_expected(exp_end);
    got_q.delete();
    mon_starts   = 0;
    mon_glitches = 0;
    if (kick == 0) begin
      i_rst     = 1'b0;
      base      = cyc;
      exp_delay = PWR;
    end else begin
      i_restart = 1'b1;
      base      = cyc;
      @(negedge clk);
      i_restart = 1'b0;
      check({tag, "_kick_done"}, o_config_done, 0);
      check({tag, "_kick_err"}, o_error, 0);
      check({tag, "_kick_busy"}, o_busy, 1);
      exp_delay = PWR + 1;  // the restart pulse itself takes one clock before the wait starts
    end

    for (int i = 0; i < LIMIT; i++) begin
      if (o_config_done || o_error) break;
      if (hook == 1 && !hooked && mon_starts == 2 && mon_in_xfer) begin
        hooked    = 1'b1;
        i_restart = 1'b1;
        @(negedge clk);
        i_restart = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_midrestart_idx"}, o_word_idx, 1);
        check({tag, "_midrestart_busy"}, o_busy, 1);
      end
      if (hook == 2 && !hooked && mon_starts == 6 && mon_in_xfer && mon_nbytes == 1) begin
        hooked = 1'b1;
        repeat ($urandom_range(0, PERIOD * 6)) @(negedge clk);
        check({tag, "_pre_idx"}, o_word_idx, 5);
        i_rst = 1'b1;
        @(negedge clk);
        check({tag, "_rst_scl"}, o_scl, 1);
        check({tag, "_rst_sda_oe"}, o_sda_oe, 0);
        check({tag, "_rst_idx"}, o_word_idx, 0);
        check({tag, "_rst_busy"}, o_busy, 1);
        repeat (3) @(negedge clk);
        got_q.delete();
        mon_starts   = 0;
        mon_glitches = 0;
        i_rst        = 1'b0;
        base         = cyc;
        exp_delay    = PWR;
      end
      @(negedge clk);
    end
    done_cyc = cyc;

    check({tag, "_end_done"}, o_config_done, exp_end == 1);
    check({tag, "_end_error"}, o_error, exp_end == 2);
    check({tag, "_end_busy"}, o_busy, 0);
    check({tag, "_idle_scl"}, o_scl, 1);
    check({tag, "_idle_sda_oe"}, o_sda_oe, 0);
    check({tag, "_start_delay"}, mon_first_start_cyc - base - 1, exp_delay);
    check({tag, "_xfers"}, got_q.size(), exp_q.size());
    check({tag, "_sda_glitch"}, mon_glitches, 0);
    nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < nchk; k++) begin
      check($sformatf("%s_x%0d_n", tag, k), got_q[k].n, exp_q[k].n);
      check($sformatf("%s_x%0d_bytes", tag, k), got_q[k].bytes, exp_q[k].bytes);
      check($sformatf("%s_x%0d_pmin", tag, k), got_q[k].pmin, exp_q[k].pmin);
      check($sformatf("%s_x%0d_pmax", tag, k), got_q[k].pmax, exp_q[k].pmax);
    end
    d = done_cyc - mon_last_stop_cyc;
    check({tag, "_gap_window"}, (d >= GAP) && (d <= GAP + PERIOD), 1);
    repeat (100) @(negedge clk);
    check({tag, "_hold_done"}, o_config_done, exp_end == 1);
    check({tag, "_hold_error"}, o_error, exp_end == 2);
  endtask

  initial begin
    i_rst     = 1'b1;
    i_restart = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_scl", o_scl, 1);
    check("reset_sda_oe", o_sda_oe, 0);
    check("reset_busy", o_busy, 1);
    check("reset_idx", o_word_idx, 0);
    check("reset_done", o_config_done, 0);
    check("reset_error", o_error, 0);

    nack_xfer = -1;
    run_table("ack_all", 0, 0);

    nack_xfer = 3;
    nack_byte = 2;
    run_table("nack_w3b2", 1, 1);

    nack_xfer = $urandom_range(0, 10);
    nack_byte = $urandom_range(0, 2);
    run_table("nack_rand", 1, 0);

    nack_xfer   = -1;
    nack_byte   = 0;
    nack_always = 1'b1;
    run_table("nack_always", 1, 0);

    nack_always = 1'b0;
    run_table("rst_mid", 1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
